// File: rtl/rv32_dbus_bridge_if.sv
// External data-bus handshake bundle for rv32_dbus_bridge.
// The master drives the request fields; the slave returns ready, read data and error.
interface rv32_dbus_bridge_if;
   logic        valid;
   logic        ready;
   logic        write;
   logic [3:0]  mask;
   logic [31:0] address;
   logic [31:0] write_value;
   logic [31:0] read_value;
   logic        error;

   modport master (
      output valid, write, mask, address, write_value,
      input  ready, read_value, error
   );

   modport slave (
      input  valid, write, mask, address, write_value,
      output ready, read_value, error
   );
endinterface

// File: rtl/rv32_dbus_bridge.sv
// Memory-stage to data-bus bridge: one bus transaction per load/store, stalling the pipe meanwhile.
// Optional REQ-state abort after TIMEOUT_CYCLES when RV32_DBUS_TIMEOUT_EN is defined.
module rv32_dbus_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      valid_in,
   input  logic                      stall_in,
   input  logic                      data_read_in,
   input  logic                      data_write_in,
   input  logic [3:0]                data_write_mask_in,
   input  logic [31:0]               data_address_in,
   input  logic [31:0]               data_write_value_in,
   output logic [31:0]               data_read_value_out,
   output logic                      stall_out,
   output logic                      fault_out,
   rv32_dbus_bridge_if.master        bus
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, wval_q, rbuf_q;
   logic [3:0]  mask_q;
   logic        write_q, fault_q;
   logic        start, handshake, timeout;

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("rv32_dbus_bridge: TIMEOUT_CYCLES must lie in 2..65535");
   end

   assign start     = valid_in && (data_read_in || data_write_in);
   assign handshake = (state_q == REQ) && bus.ready;

`ifdef RV32_DBUS_TIMEOUT_EN
   logic [15:0] wait_q;

   // Counter holds the number of REQ cycles already spent; abort in the last allowed one.
   assign timeout = (state_q == REQ) && !bus.ready && (wait_q == 16'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         wait_q <= '0;
      else if (state_q == IDLE && start)
         wait_q <= '0;
      else if (state_q == REQ)
         wait_q <= wait_q + 16'd1;
   end
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = REQ;
         REQ:     if (handshake || timeout) state_d = DONE;
         DONE:    if (!stall_in) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // stall_out is gated by reset so the pipe is released while reset is held.
   always_comb begin
      stall_out = 1'b0;
      bus.valid = 1'b0;
      case (state_q)
         IDLE:    stall_out = reset && start;
         REQ: begin
            stall_out = 1'b1;
            bus.valid = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.write           = write_q;
   assign bus.mask            = write_q ? mask_q : '0;
   assign bus.address         = addr_q;
   assign bus.write_value     = wval_q;
   assign data_read_value_out = rbuf_q;
   assign fault_out           = fault_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q  <= '0;
         wval_q  <= '0;
         mask_q  <= '0;
         write_q <= 1'b0;
         rbuf_q  <= '0;
         fault_q <= 1'b0;
      end else begin
         fault_q <= (handshake && bus.error) || timeout;
         if (state_q == IDLE && start) begin
            addr_q  <= data_address_in;
            wval_q  <= data_write_value_in;
            mask_q  <= data_write_mask_in;
            write_q <= data_write_in;
         end
         if (handshake) begin
            if (bus.error)
               rbuf_q <= '0;
            else if (!write_q)
               rbuf_q <= bus.read_value;
         end else if (timeout) begin
            rbuf_q <= '0;
         end
      end
   end

endmodule
